// File: rtl/kbd_scan_ctrl_if.sv
// Bundle of the scancode, ROM-lookup and ASCII-FIFO signals of kbd_scan_ctrl.
// The slave modport is the controller's view; master is the environment's view
// (PS/2 receiver, translation ROM bank and display consumer).
interface kbd_scan_ctrl_if #(
  parameter int FIFO_AW = 3
);
  logic             code_valid;
  logic [7:0]       code;
  logic [7:0]       lut_addr;
  logic             lut_caps;
  logic             lut_shift;
  logic [7:0]       lut_data;
  logic             ascii_rd;
  logic [7:0]       ascii_out;
  logic             ascii_valid;
  logic [FIFO_AW:0] fifo_count;
  logic             caps_state;
  logic             overflow;

  modport master (
    output code_valid, code, lut_data, ascii_rd,
    input  lut_addr, lut_caps, lut_shift, ascii_out, ascii_valid,
           fifo_count, caps_state, overflow
  );

  modport slave (
    input  code_valid, code, lut_data, ascii_rd,
    output lut_addr, lut_caps, lut_shift, ascii_out, ascii_valid,
           fifo_count, caps_state, overflow
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scancode decoder: tracks F0/E0 prefixes, shift and caps-lock state,
// issues one registered ROM lookup per printable make code and queues the
// non-zero ASCII results in a show-ahead FIFO.
module kbd_scan_ctrl #(
  parameter int         FIFO_AW     = 3,
  parameter logic [7:0] LSHIFT_CODE = 8'h12,
  parameter logic [7:0] RSHIFT_CODE = 8'h59,
  parameter logic [7:0] CAPS_CODE   = 8'h58
) (
  input logic            clk,
  input logic            reset,
  kbd_scan_ctrl_if.slave bus
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [7:0]       BRK_CODE = 8'hF0;
  localparam logic [7:0]       EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BRK    = 2'd1,
    EXT    = 2'd2,
    EXTBRK = 2'd3
  } state_t;

  state_t             state_r;
  logic               lshift_r;
  logic               rshift_r;
  logic               caps_r;
  logic               caps_held_r;
  logic               lk_pend_r;
  logic [7:0]         lut_addr_r;
  logic               lut_caps_r;
  logic               lut_shift_r;

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               overflow_r;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               drop_s;

  // Prefix decoder, modifier tracking and lookup-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      lshift_r    <= 1'b0;
      rshift_r    <= 1'b0;
      caps_r      <= 1'b0;
      caps_held_r <= 1'b0;
      lk_pend_r   <= 1'b0;
      lut_addr_r  <= 8'h00;
      lut_caps_r  <= 1'b0;
      lut_shift_r <= 1'b0;
    end else begin
      // A lookup is sampled exactly one cycle after it was issued.
      lk_pend_r <= 1'b0;
      if (bus.code_valid) begin
        case (state_r)
          IDLE: begin
            if (bus.code == BRK_CODE) begin
              state_r <= BRK;
            end else if (bus.code == EXT_CODE) begin
              state_r <= EXT;
            end else if (bus.code == LSHIFT_CODE) begin
              lshift_r <= 1'b1;
            end else if (bus.code == RSHIFT_CODE) begin
              rshift_r <= 1'b1;
            end else if (bus.code == CAPS_CODE) begin
              // Typematic repeats of a held caps key must not re-toggle.
              if (!caps_held_r) begin
                caps_r      <= ~caps_r;
                caps_held_r <= 1'b1;
              end
            end else begin
              // Modifier values from before this edge select the ROM page.
              lut_addr_r  <= bus.code;
              lut_caps_r  <= caps_r;
              lut_shift_r <= lshift_r | rshift_r;
              lk_pend_r   <= 1'b1;
            end
          end
          BRK: begin
            if (bus.code == LSHIFT_CODE) begin
              lshift_r <= 1'b0;
            end else if (bus.code == RSHIFT_CODE) begin
              rshift_r <= 1'b0;
            end else if (bus.code == CAPS_CODE) begin
              caps_held_r <= 1'b0;
            end
            state_r <= IDLE;
          end
          EXT: begin
            // Extended keys never touch modifiers or produce characters.
            state_r <= (bus.code == BRK_CODE) ? EXTBRK : IDLE;
          end
          EXTBRK: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // FIFO push/pop qualification; a full FIFO accepts a push only alongside a pop.
  always_comb begin
    push_s  = lk_pend_r && (bus.lut_data != 8'h00);
    pop_s   = bus.ascii_rd && (count_r != '0);
    full_s  = (count_r == FULL_CNT);
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
  end

  // Circular ASCII buffer with occupancy counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= bus.lut_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.lut_addr    = lut_addr_r;
  assign bus.lut_caps    = lut_caps_r;
  assign bus.lut_shift   = lut_shift_r;
  assign bus.ascii_out   = mem_r[rd_ptr_r];
  assign bus.ascii_valid = (count_r != '0);
  assign bus.fifo_count  = count_r;
  assign bus.caps_state  = caps_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: directed scenarios plus a random byte stream,
// all checked against a keystroke-level reference model and a byte queue.
module tb_kbd_scan_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  kbd_scan_ctrl_if #(.FIFO_AW(AW)) kif();

  kbd_scan_ctrl #(.FIFO_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  // Translation ROM bank: a few letters and digits, everything else 0.
  function automatic logic [7:0] rom(input logic [7:0] a, input logic caps, input logic sh);
    logic [7:0] base;
    case (a)
      8'h1C: base = 8'h61;
      8'h32: base = 8'h62;
      8'h21: base = 8'h63;
      8'h23: base = 8'h64;
      8'h24: base = 8'h65;
      8'h16: return sh ? 8'h21 : 8'h31;
      8'h1E: return sh ? 8'h40 : 8'h32;
      default: return 8'h00;
    endcase
    return (caps ^ sh) ? (base - 8'h20) : base;
  endfunction

  assign kif.lut_data = rom(kif.lut_addr, kif.lut_caps, kif.lut_shift);

  // Reference model: key-level state and the expected FIFO contents.
  logic       m_lsh, m_rsh, m_caps, m_held, m_brk, m_ext, m_ovf;
  logic       m_pend;
  logic [7:0] m_pend_val, m_addr;
  logic       m_mcaps, m_mshift;
  logic [7:0] m_q[$];

  task automatic model_clear();
    m_lsh = 1'b0; m_rsh = 1'b0; m_caps = 1'b0; m_held = 1'b0;
    m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
    m_pend_val = 8'h00; m_addr = 8'h00; m_mcaps = 1'b0; m_mshift = 1'b0;
    m_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12) m_lsh = 1'b0;
        else if (b == 8'h59) m_rsh = 1'b0;
        else if (b == 8'h58) m_held = 1'b0;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_ext) begin
      m_ext = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'h12) begin
      m_lsh = 1'b1;
    end else if (b == 8'h59) begin
      m_rsh = 1'b1;
    end else if (b == 8'h58) begin
      if (!m_held) begin
        m_caps = ~m_caps;
        m_held = 1'b1;
      end
    end else begin
      m_addr     = b;
      m_mcaps    = m_caps;
      m_mshift   = m_lsh | m_rsh;
      m_pend     = 1'b1;
      m_pend_val = rom(b, m_caps, m_lsh | m_rsh);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic rd);
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend && m_pend_val != 8'h00) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(m_pend_val);
    end
    m_pend = 1'b0;
    if (v) model_byte(c);
  endtask

  task automatic cycle(input logic v, input logic [7:0] c, input logic rd);
    @(negedge clk);
    kif.code_valid = v;
    kif.code       = c;
    kif.ascii_rd   = rd;
    @(posedge clk);
    model_edge(v, c, rd);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic [7:0] c, input logic rd);
    @(negedge clk);
    reset          = 1'b1;
    kif.code_valid = v;
    kif.code       = c;
    kif.ascii_rd   = rd;
    @(posedge clk);
    model_clear();
    #1;
    reset          = 1'b0;
    kif.code_valid = 1'b0;
    kif.ascii_rd   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 8'h1C, 1'b1);
    n_vec++; if (kif.lut_addr !== 8'h00) begin n_err++; $display("FAIL rst_lut_addr: got %h want 00", kif.lut_addr); end
    n_vec++; if (kif.lut_caps !== 1'b0) begin n_err++; $display("FAIL rst_lut_caps: got %b want 0", kif.lut_caps); end
    n_vec++; if (kif.lut_shift !== 1'b0) begin n_err++; $display("FAIL rst_lut_shift: got %b want 0", kif.lut_shift); end
    n_vec++; if (kif.ascii_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", kif.ascii_valid); end
    n_vec++; if (kif.ascii_out !== 8'h00) begin n_err++; $display("FAIL rst_ascii_out: got %h want 00", kif.ascii_out); end
    n_vec++; if (kif.fifo_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", kif.fifo_count); end
    n_vec++; if (kif.caps_state !== 1'b0) begin n_err++; $display("FAIL rst_caps: got %b want 0", kif.caps_state); end
    n_vec++; if (kif.overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", kif.overflow); end
  endtask

  task automatic test_basic();
    do_reset(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    n_vec++; if (kif.lut_addr !== 8'h1C) begin n_err++; $display("FAIL basic_lut_addr: got %h want 1c", kif.lut_addr); end
    n_vec++; if ({kif.lut_caps, kif.lut_shift} !== 2'b00) begin n_err++; $display("FAIL basic_sel: got %b want 00", {kif.lut_caps, kif.lut_shift}); end
    n_vec++; if (kif.ascii_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", kif.ascii_valid); end
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.ascii_valid !== 1'b1 || kif.ascii_out !== 8'h61) begin n_err++; $display("FAIL basic_out: got %b/%h want 1/61", kif.ascii_valid, kif.ascii_out); end
    n_vec++; if (kif.fifo_count !== 4'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", kif.fifo_count); end
    cycle(1'b0, 8'h00, 1'b1);
    n_vec++; if (kif.fifo_count !== 4'd0) begin n_err++; $display("FAIL basic_pop: got %0d want 0", kif.fifo_count); end
  endtask

  task automatic test_shift();
    do_reset(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    n_vec++; if (kif.lut_shift !== 1'b1) begin n_err++; $display("FAIL shift_on: got %b want 1", kif.lut_shift); end
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    n_vec++; if (kif.lut_shift !== 1'b0) begin n_err++; $display("FAIL shift_off: got %b want 0", kif.lut_shift); end
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.fifo_count !== 4'd2 || kif.ascii_out !== 8'h41) begin n_err++; $display("FAIL shift_fifo: got %0d/%h want 2/41", kif.fifo_count, kif.ascii_out); end
    cycle(1'b0, 8'h00, 1'b1);
    n_vec++; if (kif.ascii_out !== 8'h61) begin n_err++; $display("FAIL shift_second: got %h want 61", kif.ascii_out); end
  endtask

  task automatic test_caps();
    logic [7:0] seq [8] = '{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58};
    logic       exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      n_vec++; if (kif.caps_state !== exp[i]) begin n_err++; $display("FAIL caps_step%0d: got %b want %b", i, kif.caps_state, exp[i]); end
    end
  endtask

  task automatic test_ext();
    logic [7:0] seq [12] = '{8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h12, 8'hF0, 8'h1C, 8'hE0};
    do_reset(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b1, seq[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.fifo_count !== 4'd0) begin n_err++; $display("FAIL ext_nowrite: got %0d want 0", kif.fifo_count); end
    n_vec++; if (kif.caps_state !== 1'b0) begin n_err++; $display("FAIL ext_caps: got %b want 0", kif.caps_state); end
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.ascii_out !== 8'h41 || kif.fifo_count !== 4'd1) begin n_err++; $display("FAIL ext_idle_shift: got %h/%0d want 41/1", kif.ascii_out, kif.fifo_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h16, 8'h1E, 8'h1C, 8'h32};
    logic [7:0] want  [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h31, 8'h32, 8'h61};
    do_reset(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, codes[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", kif.fifo_count); end
    n_vec++; if (kif.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", kif.overflow); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (kif.ascii_out !== want[i]) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, kif.ascii_out, want[i]); end
      cycle(1'b0, 8'h00, 1'b1);
    end
    n_vec++; if (kif.fifo_count !== 4'd0 || kif.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_end: got %0d/%b want 0/1", kif.fifo_count, kif.overflow); end
    cycle(1'b0, 8'h00, 1'b1);
    n_vec++; if (kif.fifo_count !== 4'd0) begin n_err++; $display("FAIL ovf_underflow: got %0d want 0", kif.fifo_count); end
  endtask

  task automatic test_full_pop();
    do_reset(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h24, 1'b0);
    cycle(1'b1, 8'h16, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    n_vec++; if (kif.fifo_count !== 4'd8 || kif.overflow !== 1'b0) begin n_err++; $display("FAIL fullpop: got %0d/%b want 8/0", kif.fifo_count, kif.overflow); end
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
    n_vec++; if (kif.ascii_out !== 8'h31 || kif.fifo_count !== 4'd1) begin n_err++; $display("FAIL fullpop_tail: got %h/%0d want 31/1", kif.ascii_out, kif.fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    do_reset(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    n_vec++; if (kif.fifo_count !== 4'd0 || kif.lut_addr !== 8'h00) begin n_err++; $display("FAIL midrst: got %0d/%h want 0/00", kif.fifo_count, kif.lut_addr); end
    cycle(1'b1, 8'hF0, 1'b0);
    do_reset(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    n_vec++; if (kif.lut_shift !== 1'b1) begin n_err++; $display("FAIL midrst_prefix: got %b want 1", kif.lut_shift); end
  endtask

  task automatic test_random();
    logic [7:0] tbl [12] = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h75, 8'h24};
    logic [7:0] c;
    logic       v, rd;
    do_reset(1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      c  = (($urandom % 10) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 11)];
      v  = ($urandom % 3) != 0;
      rd = ($urandom % 4) == 0;
      cycle(v, c, rd);
      n_vec++; if (kif.fifo_count !== 4'(m_q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, kif.fifo_count, m_q.size()); end
      n_vec++; if (kif.ascii_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b", n, kif.ascii_valid); end
      if (m_q.size() != 0) begin
        n_vec++; if (kif.ascii_out !== m_q[0]) begin n_err++; $display("FAIL rnd_out@%0d: got %h want %h", n, kif.ascii_out, m_q[0]); end
      end
      n_vec++; if (kif.caps_state !== m_caps || kif.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_flags@%0d: got %b%b want %b%b", n, kif.caps_state, kif.overflow, m_caps, m_ovf); end
      n_vec++; if ({kif.lut_addr, kif.lut_caps, kif.lut_shift} !== {m_addr, m_mcaps, m_mshift}) begin n_err++; $display("FAIL rnd_lut@%0d: got %h%b%b want %h%b%b", n, kif.lut_addr, kif.lut_caps, kif.lut_shift, m_addr, m_mcaps, m_mshift); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    kif.code_valid = 1'b0;
    kif.code       = 8'h00;
    kif.ascii_rd   = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_ext();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequences the PS/2 scancode-to-ASCII translation path.
- Takes raw scancode bytes from the PS/2 receiver and tracks make, break (F0) and extended (E0) prefixes.
- Maintains shift and caps-lock state, issues one registered lookup per printable make code to the scancode translation ROM bank, and queues the returned ASCII bytes in a small FIFO for the display/terminal consumer.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries.
- LSHIFT_CODE, 8'h12, left-shift scancode.
- RSHIFT_CODE, 8'h59, right-shift scancode.
- CAPS_CODE, 8'h58, caps-lock scancode.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle strobe: code holds a new scancode byte.
- code  in  8  scancode byte from PS/2 receiver.
- lut_addr  out  8  address to translation ROM bank (registered).
- lut_caps  out  1  caps select to translation ROM bank (registered).
- lut_shift  out  1  shift select to translation ROM bank (registered).
- lut_data  in  8  ASCII returned by ROM bank; combinational from lut_addr/lut_caps/lut_shift.
- ascii_rd  in  1  consumer pop request.
- ascii_out  out  8  FIFO head byte; valid when ascii_valid=1.
- ascii_valid  out  1  FIFO not empty.
- fifo_count  out  FIFO_AW+1  current occupancy.
- caps_state  out  1  caps-lock toggle state (LED drive).
- overflow  out  1  sticky: an ASCII byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=1 at clk edge): FSM=IDLE; lshift, rshift, caps_state, caps_held, lk_pend, overflow = 0; FIFO emptied (fifo_count=0, ascii_valid=0, ascii_out=0); lut_addr=0, lut_caps=0, lut_shift=0. Reset wins over every other input in the same cycle, including mid-lookup and mid-prefix.
- Decoder FSM acts only on cycles with code_valid=1:
  - IDLE: F0 -> BRK; E0 -> EXT; other -> make handling, stay IDLE.
  - BRK: byte is break code -> break handling, -> IDLE.
  - EXT: F0 -> EXTBRK; other -> discard, -> IDLE.
  - EXTBRK: any byte -> discard, -> IDLE.
  - Extended keys never change modifiers or produce ASCII.
- Make handling:
  - LSHIFT_CODE sets lshift; RSHIFT_CODE sets rshift.
  - CAPS_CODE: if caps_held=0, toggle caps_state and set caps_held. Typematic repeats while held do not toggle.
  - Any other code: lut_addr<=code, lut_caps<=caps_state, lut_shift<=lshift|rshift, lk_pend<=1. Uses modifier values before this edge.
- Break handling: LSHIFT_CODE clears lshift; RSHIFT_CODE clears rshift; CAPS_CODE clears caps_held; other codes do nothing.
- Lookup pipeline:
  - Latency from code_valid edge to FIFO write is 2 clk: cycle N registers lut_*; cycle N+1 samples lut_data with lk_pend=1.
  - If lut_data != 0, push it; lut_data == 0 (untranslatable) is discarded silently.
  - lk_pend clears after one cycle unless reloaded.
  - Back-to-back code_valid on consecutive cycles is fully pipelined; no byte is lost.
  - lut_* outputs hold their value between lookups.
- FIFO:
  - Circular buffer, pointers of FIFO_AW bits wrap at depth; count 0..2**FIFO_AW.
  - Show-ahead: ascii_out = mem[rd_ptr] combinationally; ascii_valid = (count != 0).
  - Pop on ascii_rd & ascii_valid. ascii_rd when empty is ignored; count never underflows.
  - Push when full without a pop the same cycle: byte dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle: allowed when full or empty-with-pop-invalid as follows:
    - Full + pop: both occur, count unchanged.
    - Empty: pop ignored, push occurs, count becomes 1.
  - overflow is cleared only by reset.

Test Plan:
- Reset then code 1C ('a' key), lut_data model = ASCII -> lut_addr=1C, caps=0, shift=0 one cycle after strobe; ascii_out=8'h61 with ascii_valid=1 two cycles after strobe; fifo_count=1.
- Sequence 12, 1C, F0 1C, F0 12 -> second lookup has lut_shift=1, FIFO holds 8'h41; after F0 12, next 1C gives lut_shift=0.
- 58, 58, 58 (repeat), F0 58, 58, F0 58 -> caps_state toggles 0->1 on first make, stays 1 through repeats, returns to 0 on second press.
- E0 75, E0 F0 75, then F0 1C -> no FIFO writes, FSM back in IDLE, shift/caps unchanged.
- With ascii_rd=0, 9 printable makes at depth 8 -> fifo_count=8, overflow=1, ascii_out still the first byte; then assert ascii_rd for 8 cycles -> bytes drain in order, fifo_count=0, overflow stays 1.
- Full FIFO, ascii_rd=1 in the same cycle as a push -> count stays 8, no overflow, new byte at tail. Assert reset between a code_valid edge and its push -> no push, all outputs zero.
